axis_hdr_insert_pack: RTL
=========================

# axis_hdr_insert_pack

Parametrised AXI-Stream header inserter with full-rate byte packing. It accepts one header beat with 0..N valid bytes per packet and prepends those bytes to the packet's data stream. It repacks the result into full output beats, so no bubbles appear inside a packet. It sits at the same point in the datapath as the existing single-width inserter and replaces it wherever variable header length, full throughput or a registered output is needed.

## Interface
- DATA_WD, 32, data width in bits; multiple of 8, range 16..512.
- DATA_BYTE_WD, DATA_WD/8, lane count N.
- PKT_CNT_WD, 16, width of the completed-packet counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- s00_axis_tvalid / s00_axis_tready  in / out  1 / 1  header handshake.
- s00_axis_tdata  in  DATA_WD  header bytes, right-aligned.
- s00_axis_tkeep  in  DATA_BYTE_WD  contiguous ones from bit 0; H = popcount, 0..N.
- s01_axis_tvalid / s01_axis_tready  in / out  1 / 1  data handshake.
- s01_axis_tdata / s01_axis_tkeep / s01_axis_tlast  in  DATA_WD / DATA_BYTE_WD / 1  packet data.
- m_axis_tvalid / m_axis_tready  out / in  1 / 1  output handshake.
- m_axis_tdata / m_axis_tkeep / m_axis_tlast  out  DATA_WD / DATA_BYTE_WD / 1  packed output.
- pkt_cnt  out  PKT_CNT_WD  count of output tlast handshakes; wraps to 0.

## Operation
- Byte order:
  - The byte in the highest lane is first in time.
  - Non-last data beats have full keep.
  - The last data beat has keep left-aligned (high lanes), L = 1..N bytes.
  - Output follows the same rules.
- Residue register: holds up to N bytes plus a count R (0..N). Packing arithmetic uses a 2N-byte concatenation {residue(R), data(D)}. Total T = R + D.
- States:
  - IDLE
    - s00_tready = 1 when the output register is free; s01_tready = 0.
    - On header accept: residue = header bytes, R = H.
    - If H = N, go to HDR; otherwise go to STREAM.
  - HDR
    - Emit the header as a full beat (keep all ones, tlast 0). Set R = 0 and go to STREAM.
    - No data is consumed in this state.
  - STREAM
    - s01_tready when the output register is free.
    - Per accepted data beat:
      - If not last: emit the top N bytes of T; new R = T−N, the remaining bytes.
      - If last and T ≤ N: emit T bytes left-aligned with tlast = 1, then go to IDLE.
      - If last and T > N: emit N bytes, set R = T−N, then go to TAIL.
  - TAIL: emit R bytes left-aligned with tlast = 1. Set R = 0 and go to IDLE.
- H = 0: data passes unchanged, beat for beat.
- Output register: loads when empty, or when m_axis_tvalid && m_axis_tready occurs in the same cycle. Load and drain in the same cycle is legal.
- Input packets carry no validation.
  - Non-contiguous header keep has undefined output bytes. The beat count still follows popcount.
  - Never emit keep = 0 with tvalid = 1.
- pkt_cnt increments on every m_axis tvalid && tready && tlast.

## Timing
- Reset, asynchronous on rst_n low:
  - state IDLE, R = 0, output register empty.
  - m_axis_tvalid, tdata, tkeep, tlast all 0.
  - pkt_cnt 0.
  - s00_axis_tready = 1; s01_axis_tready = 0.
- Reset asserted mid-packet discards the residue and output beat immediately. The partial packet is lost and no tlast is emitted.
- Latency is one cycle: an input accepted in cycle t is presented on m_axis in t+1.
- Throughput:
  - One data beat per cycle in STREAM with m_axis_tready held at 1.
  - One extra output cycle for HDR and for TAIL.
  - One idle input cycle between the last data beat and the next header accept.
- Backpressure: while m_axis_tvalid && !m_axis_tready, the m_axis signals hold stable and both input readies are 0.
- Readies are combinational from state, output-register occupancy and m_axis_tready. They never depend on s*_tvalid.
- Data arriving before its header waits (s01_tready = 0 in IDLE). A header arriving mid-packet waits until IDLE.

## Test plan
Each scenario uses DATA_WD = 32, with m_axis_tready = 1 unless noted.

1. **H = 2.** Stimulus: header 0x00001122 keep 0011; data 0xA1A2A3A4, 0xB1B2B3B4 (full), then 0xC1C20000 keep 1100 last. Required output: 0x1122A1A2, 0xA3A4B1B2, 0xB3B4C1C2, the last with keep 1111 and tlast. Required pkt_cnt = 1.
2. **Tail beat.** Stimulus: header 0x00112233 keep 0111; data 0xA1A2A3A4, then 0xB1B2B300 keep 1110 last. Required output: 0x112233A1, 0xA2A3A4B1, then 0xB2B30000 keep 1100 tlast (TAIL).
3. **Full header.** Stimulus: header 0x11223344 keep 1111; data 0xA1000000 keep 1000 last. Required output: 0x11223344 keep 1111 tlast 0, then 0xA1000000 keep 1000 tlast 1.
4. **Passthrough and back-to-back.** Stimulus: H = 0 packet followed immediately by an H = 2 packet. Required output: the first packet is identical to its input. The second packet is packed as in scenario 1, with exactly one idle input cycle between the packets.
5. **Backpressure.** Stimulus: random m_axis_tready (50 %) over 1000 packets with random H and L. Required response: the byte stream equals the scoreboard; m_axis signals stay stable while stalled; pkt_cnt = 1000 mod 2^16.
6. **Reset mid-packet.** Stimulus: rst_n pulled low asynchronously mid-STREAM. Required response: m_axis_tvalid = 0 the same instant. After release, s00_tready = 1, and the next packet outputs correctly with pkt_cnt restarting at 0.

Source files
------------

// File: rtl/axis_hdr_insert_pack.sv
// axis_hdr_insert_pack: prepends a 0..N byte header to an AXI-Stream packet
// and repacks the result into full beats behind a registered output.
module axis_hdr_insert_pack #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int PKT_CNT_WD   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s00_axis_tvalid,
    output logic                    s00_axis_tready,
    input  logic [DATA_WD-1:0]      s00_axis_tdata,
    input  logic [DATA_BYTE_WD-1:0] s00_axis_tkeep,
    input  logic                    s01_axis_tvalid,
    output logic                    s01_axis_tready,
    input  logic [DATA_WD-1:0]      s01_axis_tdata,
    input  logic [DATA_BYTE_WD-1:0] s01_axis_tkeep,
    input  logic                    s01_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WD-1:0]      m_axis_tdata,
    output logic [DATA_BYTE_WD-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [PKT_CNT_WD-1:0]   pkt_cnt
);
    localparam int N  = DATA_BYTE_WD;
    localparam int CW = $clog2(2 * N + 1);
    localparam logic [CW-1:0] NB = CW'(N);

    typedef enum logic [1:0] {IDLE, HDR, STREAM, TAIL} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_WD-1:0]   res_q;
    logic [DATA_WD-1:0]   res_d;
    logic [CW-1:0]        r_q;
    logic [CW-1:0]        r_d;
    logic                 out_free;
    logic                 hdr_fire;
    logic                 dat_fire;
    logic                 load;
    logic [DATA_WD-1:0]   out_data;
    logic [N-1:0]         out_keep;
    logic                 out_last;
    logic [DATA_WD-1:0]   hdr_m;
    logic [DATA_WD-1:0]   dat_m;
    logic [DATA_WD-1:0]   hdr_left;
    logic [CW-1:0]        hdr_cnt;
    logic [CW-1:0]        dat_cnt;
    logic [CW-1:0]        tot;
    logic [2*DATA_WD-1:0] cat;

    function automatic logic [CW-1:0] popc(input logic [N-1:0] k);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + CW'(k[i]);
        return c;
    endfunction

    function automatic logic [DATA_WD-1:0] lane_mask(input logic [N-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < N; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // n bytes in the high lanes; saturates to all ones for n >= N
    function automatic logic [N-1:0] lkeep(input logic [CW-1:0] n);
        return ~({N{1'b1}} >> n);
    endfunction

    assign out_free        = !m_axis_tvalid || m_axis_tready;
    assign s00_axis_tready = (state == IDLE) && out_free;
    assign s01_axis_tready = (state == STREAM) && out_free;
    assign hdr_fire        = s00_axis_tvalid && s00_axis_tready;
    assign dat_fire        = s01_axis_tvalid && s01_axis_tready;

    assign hdr_m    = s00_axis_tdata & lane_mask(s00_axis_tkeep);
    assign dat_m    = s01_axis_tdata & lane_mask(s01_axis_tkeep);
    assign hdr_cnt  = popc(s00_axis_tkeep);
    assign dat_cnt  = popc(s01_axis_tkeep);
    assign hdr_left = hdr_m << {NB - hdr_cnt, 3'b000};
    assign tot      = r_q + dat_cnt;

    // residue sits in the high lanes; data slides in right behind it
    assign cat = {res_q, {DATA_WD{1'b0}}}
               | ({dat_m, {DATA_WD{1'b0}}} >> {r_q, 3'b000});

    always_comb begin
        state_nxt = state;
        res_d     = res_q;
        r_d       = r_q;
        load      = 1'b0;
        out_data  = cat[2*DATA_WD-1 -: DATA_WD];
        out_keep  = '1;
        out_last  = 1'b0;
        unique case (state)
            IDLE: if (hdr_fire) begin
                res_d     = hdr_left;
                r_d       = hdr_cnt;
                state_nxt = (hdr_cnt == NB) ? HDR : STREAM;
            end
            HDR: if (out_free) begin
                load      = 1'b1;
                out_data  = res_q;
                res_d     = '0;
                r_d       = '0;
                state_nxt = STREAM;
            end
            STREAM: if (dat_fire) begin
                out_keep = lkeep(tot);
                load     = (tot != '0);
                if (s01_axis_tlast && tot <= NB) begin
                    out_last  = 1'b1;
                    res_d     = '0;
                    r_d       = '0;
                    state_nxt = IDLE;
                end else begin
                    res_d = cat[DATA_WD-1:0];
                    r_d   = (tot > NB) ? tot - NB : '0;
                    if (s01_axis_tlast) state_nxt = TAIL;
                end
            end
            TAIL: if (out_free) begin
                load      = 1'b1;
                out_data  = res_q;
                out_keep  = lkeep(r_q);
                out_last  = 1'b1;
                res_d     = '0;
                r_d       = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            res_q <= '0;
            r_q   <= '0;
        end else begin
            state <= state_nxt;
            res_q <= res_d;
            r_q   <= r_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_free) begin
            m_axis_tvalid <= load;
            if (load) begin
                m_axis_tdata <= out_data;
                m_axis_tkeep <= out_keep;
                m_axis_tlast <= out_last;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end
endmodule
